// File: rtl/inputbuf_sp_fifo_ctrl.sv
// inputbuf_sp_fifo_ctrl: AXI-Stream FIFO built on one single-port RAM with a 2-cycle read path.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_tdata/tvalid/tready    input stream; tready marks a granted RAM write
//   out_tdata/tvalid/tready   output stream from a 3-entry register buffer
//   ram_en/enq/we/addr/wdata  RAM port drive, ram_rdq RAM read data
//   count                     words held: RAM + reads in flight + output buffer
module inputbuf_sp_fifo_ctrl #(
    parameter int DWIDTH = 18,
    parameter int AWIDTH = 10,
    parameter int DEPTH  = 2**AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] in_tdata,
    input  logic              in_tvalid,
    output logic              in_tready,
    output logic [DWIDTH-1:0] out_tdata,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic              ram_en,
    output logic              ram_enq,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_wdata,
    input  logic [DWIDTH-1:0] ram_rdq,
    output logic [AWIDTH+1:0] count
);
    localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);
    localparam logic [AWIDTH:0]   FULL = (AWIDTH + 1)'(DEPTH);
    logic [AWIDTH-1:0] wr_ptr, rd_ptr;
    logic [AWIDTH:0]   ram_cnt;
    logic              v1, v2, last_wr;
    logic [1:0]        obuf_cnt, widx;
    logic [DWIDTH-1:0] obuf [3];
    logic              wr_req, rd_req, wr_gnt, rd_gnt, pop;
    assign wr_req = !rst && in_tvalid && ram_cnt < FULL;
    // A read is only issued when a buffer slot is already reserved for it,
    // so the output buffer can never overflow under backpressure.
    assign rd_req = !rst && ram_cnt != '0 && ({1'b0, obuf_cnt} + {2'b0, v1} + {2'b0, v2}) < 3'd3;
    // Round-robin on contention: the write wins unless the last grant was a write.
    assign wr_gnt = wr_req && (!rd_req || !last_wr);
    assign rd_gnt = rd_req && !wr_gnt;
    assign pop = out_tvalid && out_tready;
    assign widx = obuf_cnt - {1'b0, pop};
    assign in_tready = wr_gnt;
    assign ram_en = wr_gnt || rd_gnt;
    assign ram_we = wr_gnt;
    assign ram_addr = rd_gnt ? rd_ptr : wr_ptr;
    assign ram_wdata = in_tdata;
    assign ram_enq = !rst;
    assign out_tvalid = obuf_cnt != 2'd0;
    assign out_tdata = obuf[0];
    assign count = (AWIDTH + 2)'(ram_cnt) + (AWIDTH + 2)'(obuf_cnt) + (AWIDTH + 2)'(v1) + (AWIDTH + 2)'(v2);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            obuf_cnt <= 2'd0;
            last_wr  <= 1'b0;
        end else begin
            if (wr_gnt) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            if (rd_gnt) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
            ram_cnt <= wr_gnt ? ram_cnt + 1'b1 : rd_gnt ? ram_cnt - 1'b1 : ram_cnt;
            if (wr_gnt || rd_gnt) last_wr <= wr_gnt;
            v1 <= rd_gnt;
            v2 <= v1;
            obuf_cnt <= obuf_cnt + {1'b0, v2} - {1'b0, pop};
        end
    end
    // Head-at-0 shift buffer: a pop shifts down, a push lands just past the surviving entries.
    always_ff @(posedge clk) begin
        obuf[0] <= (v2 && widx == 2'd0) ? ram_rdq : pop ? obuf[1] : obuf[0];
        obuf[1] <= (v2 && widx == 2'd1) ? ram_rdq : pop ? obuf[2] : obuf[1];
        obuf[2] <= (v2 && widx == 2'd2) ? ram_rdq : obuf[2];
    end
endmodule

// File: tb/tb_inputbuf_sp_fifo_ctrl.sv
// tb_inputbuf_sp_fifo_ctrl: randomized and directed checks of the single-port RAM FIFO controller.
module tb_inputbuf_sp_fifo_ctrl;
    logic        clk, rst, in_tvalid, out_tready, sel;
    logic [17:0] in_tdata;
    logic        itr8, otv8, en8, enq8, we8, itr6, otv6, en6, enq6, we6;
    logic [17:0] otd8, wd8, rdq8, otd6, wd6, rdq6, d8, d6;
    logic [2:0]  addr8, addr6;
    logic [4:0]  cnt8, cnt6;
    logic [17:0] m8 [8];
    logic [17:0] m6 [8];
    logic        in_tready, out_tvalid, ram_en, ram_enq, ram_we;
    logic [17:0] out_tdata;
    logic [2:0]  ram_addr;
    logic [4:0]  count;
    int          total = 0, bad = 0, qn;
    logic        acc, popd, s_itr, s_otv, s_en, s_we;
    logic [17:0] pd, ex;
    logic [4:0]  s_cnt;
    logic [2:0]  s_addr;
    logic [17:0] q [$];

    inputbuf_sp_fifo_ctrl #(.DWIDTH(18), .AWIDTH(3), .DEPTH(8)) u8 (
        .clk(clk), .rst(rst), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(itr8),
        .out_tdata(otd8), .out_tvalid(otv8), .out_tready(out_tready), .ram_en(en8), .ram_enq(enq8),
        .ram_we(we8), .ram_addr(addr8), .ram_wdata(wd8), .ram_rdq(rdq8), .count(cnt8));
    inputbuf_sp_fifo_ctrl #(.DWIDTH(18), .AWIDTH(3), .DEPTH(6)) u6 (
        .clk(clk), .rst(rst), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(itr6),
        .out_tdata(otd6), .out_tvalid(otv6), .out_tready(out_tready), .ram_en(en6), .ram_enq(enq6),
        .ram_we(we6), .ram_addr(addr6), .ram_wdata(wd6), .ram_rdq(rdq6), .count(cnt6));

    // Write-first single-port RAM with output pipeline register: data 2 cycles after the read.
    always @(posedge clk) begin
        if (en8) begin
            if (we8) m8[addr8] <= wd8;
            d8 <= we8 ? wd8 : m8[addr8];
        end
        if (enq8) rdq8 <= d8;
        if (en6) begin
            if (we6) m6[addr6] <= wd6;
            d6 <= we6 ? wd6 : m6[addr6];
        end
        if (enq6) rdq6 <= d6;
    end

    assign in_tready  = sel ? itr6 : itr8;
    assign out_tvalid = sel ? otv6 : otv8;
    assign out_tdata  = sel ? otd6 : otd8;
    assign ram_en     = sel ? en6 : en8;
    assign ram_enq    = sel ? enq6 : enq8;
    assign ram_we     = sel ? we6 : we8;
    assign ram_addr   = sel ? addr6 : addr8;
    assign count      = sel ? cnt6 : cnt8;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // One cycle: drive inputs, sample mid-cycle, update the ideal FIFO queue.
    task automatic cyc(input logic v, input logic [17:0] d, input logic r);
        in_tvalid = v;
        in_tdata = d;
        out_tready = r;
        #4;
        qn = q.size();
        s_itr = in_tready;
        s_otv = out_tvalid;
        s_cnt = count;
        s_en = ram_en;
        s_we = ram_we;
        s_addr = ram_addr;
        acc = v && in_tready;
        popd = out_tvalid && r;
        pd = out_tdata;
        ex = 'x;
        if (popd && q.size() > 0) ex = q.pop_front();
        if (acc) q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_tvalid = 1'b0;
        out_tready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b1;
        in_tvalid = 1'b1;
        in_tdata = 18'h11;
        out_tready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        total += 7;
        if (in_tready !== 1'b0) begin bad++; $display("FAIL rst_in_tready got=%b exp=0", in_tready); end
        if (out_tvalid !== 1'b0) begin bad++; $display("FAIL rst_out_tvalid got=%b exp=0", out_tvalid); end
        if (ram_en !== 1'b0) begin bad++; $display("FAIL rst_ram_en got=%b exp=0", ram_en); end
        if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_ram_we got=%b exp=0", ram_we); end
        if (ram_enq !== 1'b0) begin bad++; $display("FAIL rst_ram_enq got=%b exp=0", ram_enq); end
        if (ram_addr !== 3'd0) begin bad++; $display("FAIL rst_ram_addr got=%0d exp=0", ram_addr); end
        if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_tvalid = 1'b0;
        #1;
        total++;
        if (ram_enq !== 1'b1) begin bad++; $display("FAIL enq_after_rst got=%b exp=1", ram_enq); end
        @(posedge clk);
        #1;
        q.delete();
    endtask

    task automatic test_latency();
        int k = 1, nout = 0, fa = -1, fv = -1;
        sel = 1'b0;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            cyc(k <= 5, 18'(k), 1'b1);
            if (s_otv && fv < 0) fv = n;
            if (acc) begin
                if (fa < 0) fa = n;
                k++;
            end
            if (popd) begin
                nout++;
                total++;
                if (pd !== ex) begin bad++; $display("FAIL lat_data got=%h exp=%h", pd, ex); end
            end
        end
        total += 2;
        if (nout != 5) begin bad++; $display("FAIL lat_nout got=%0d exp=5", nout); end
        if (fv - fa != 4) begin bad++; $display("FAIL lat_first got=%0d exp=4", fv - fa); end
    endtask

    task automatic test_full();
        int k = 1, nout = 0;
        sel = 1'b0;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            cyc(k <= 20, 18'(k), 1'b0);
            if (acc) k++;
        end
        total += 3;
        if (k - 1 != 11) begin bad++; $display("FAIL full_accepted got=%0d exp=11", k - 1); end
        if (s_itr !== 1'b0) begin bad++; $display("FAIL full_in_tready got=%b exp=0", s_itr); end
        if (s_cnt !== 5'd11) begin bad++; $display("FAIL full_count got=%0d exp=11", s_cnt); end
        for (int n = 0; n < 80 && nout < 11; n++) begin
            cyc(1'b0, 18'd0, 1'b1);
            if (popd) begin
                nout++;
                total++;
                if (pd !== ex) begin bad++; $display("FAIL full_data got=%h exp=%h", pd, ex); end
            end
        end
        cyc(1'b0, 18'd0, 1'b1);
        total += 2;
        if (nout != 11) begin bad++; $display("FAIL full_drained got=%0d exp=11", nout); end
        if (s_cnt !== 5'd0) begin bad++; $display("FAIL full_count_end got=%0d exp=0", s_cnt); end
    endtask

    task automatic test_wrap();
        int k = 1, nout = 0, maxa = 0, lastw = -1;
        bit wrapped = 0;
        sel = 1'b1;
        do_reset();
        for (int n = 0; n < 400 && nout < 30; n++) begin
            cyc(k <= 30, 18'(k), 1'b1);
            if (acc) k++;
            if (s_en) begin
                if (int'(s_addr) > maxa) maxa = int'(s_addr);
                if (s_we) begin
                    if (lastw == 5 && s_addr == 3'd0) wrapped = 1;
                    lastw = int'(s_addr);
                end
            end
            if (popd) begin
                nout++;
                total++;
                if (pd !== ex) begin bad++; $display("FAIL wrap_data got=%h exp=%h", pd, ex); end
            end
        end
        sel = 1'b0;
        total += 3;
        if (nout != 30) begin bad++; $display("FAIL wrap_nout got=%0d exp=30", nout); end
        if (maxa != 5) begin bad++; $display("FAIL wrap_max_addr got=%0d exp=5", maxa); end
        if (!wrapped) begin bad++; $display("FAIL wrap_5_to_0 got=0 exp=1"); end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        do_reset();
        for (int n = 0; n < 12; n++) begin
            cyc(1'b1, 18'(n + 100), 1'b1);
            total++;
            if ({s_en, s_we} !== {1'b1, n % 2 == 0}) begin
                bad++;
                $display("FAIL alt_we cyc=%0d got en/we=%b%b exp=1%b", n, s_en, s_we, n % 2 == 0);
            end
            if (popd) begin
                total++;
                if (pd !== ex) begin bad++; $display("FAIL alt_data got=%h exp=%h", pd, ex); end
            end
        end
    endtask

    task automatic test_random();
        int sent = 0, nout = 0;
        logic v;
        sel = 1'b0;
        do_reset();
        for (int n = 0; n < 20000 && nout < 1000; n++) begin
            v = sent < 1000 && $urandom_range(0, 9) < 7;
            cyc(v, 18'($urandom), 1'($urandom_range(0, 1)));
            if (acc) sent++;
            total++;
            if (int'(s_cnt) != qn) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", s_cnt, qn); end
            if (qn == 11) begin
                total++;
                if (s_itr !== 1'b0) begin bad++; $display("FAIL rnd_full_ready got=%b exp=0", s_itr); end
            end
            if (popd) begin
                nout++;
                total++;
                if (pd !== ex) begin bad++; $display("FAIL rnd_data n=%0d got=%h exp=%h", nout, pd, ex); end
            end
        end
        total++;
        if (nout != 1000) begin bad++; $display("FAIL rnd_nout got=%0d exp=1000", nout); end
    endtask

    task automatic test_reset_midstream();
        int got = 0;
        logic [17:0] first = '0;
        sel = 1'b0;
        do_reset();
        for (int n = 0; n < 6; n++) cyc(1'b1, 18'(n + 1), 1'b0);
        in_tvalid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        total += 3;
        if (out_tvalid !== 1'b0) begin bad++; $display("FAIL mid_out_tvalid got=%b exp=0", out_tvalid); end
        if (count !== 5'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
        if (in_tready !== 1'b0) begin bad++; $display("FAIL mid_in_tready got=%b exp=0", in_tready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        for (int n = 0; n < 30 && got == 0; n++) begin
            cyc(q.size() == 0 && n < 3, 18'h2A, 1'b1);
            if (popd) begin
                got = 1;
                first = pd;
            end
        end
        total++;
        if (first !== 18'h2A) begin bad++; $display("FAIL mid_first_out got=%h exp=02a", first); end
    endtask

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        in_tvalid = 1'b0;
        in_tdata = '0;
        out_tready = 1'b0;
        test_reset();
        test_latency();
        test_full();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
